// File: rtl/doorbell_chime_seq.sv
// Doorbell chime sequencer: edge-triggered channel select, timed play window,
// fixed-latency output delay line with busy/done status.
module doorbell_chime_seq #(
    parameter int NCH    = 4,
    parameter int W      = 8,
    parameter int DELAY  = 5,
    parameter int HOLD   = 8,
    parameter int RETRIG = 0,
    localparam int SW    = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH*W-1:0] snd,
    input  logic [SW-1:0]    sel,
    input  logic             press,
    output logic [W-1:0]     out,
    output logic             busy,
    output logic             done
);

    localparam int MAXC = (HOLD > DELAY) ? HOLD : DELAY;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD - 1);
    localparam logic [CW-1:0] DRAIN_LD = CW'(DELAY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_DRAIN
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] sel_q, sel_d;
    logic          press_q;
    logic          done_q, done_d;
    logic          rise;
    logic [W-1:0]  g;
    logic [W-1:0]  dly_q [DELAY];

    assign rise = press & ~press_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rise) begin
                    sel_d   = sel;
                    cnt_d   = HOLD_LD;
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                // retrigger wins over the end-of-window exit
                if ((RETRIG != 0) && rise) begin
                    sel_d = sel;
                    cnt_d = HOLD_LD;
                end else if (cnt_q == '0) begin
                    cnt_d   = DRAIN_LD;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // out-of-range selects match no channel and play silence
    always_comb begin
        g = '0;
        if (state_q == S_PLAY) begin
            for (int c = 0; c < NCH; c++) begin
                if (sel_q == SW'(c)) begin
                    g = snd[c*W +: W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            press_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            press_q <= press;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DELAY; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            dly_q[0] <= g;
            for (int i = 1; i < DELAY; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign out  = dly_q[DELAY-1];
    assign busy = (state_q != S_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_doorbell_chime_seq.sv
// Directed scoreboard bench for doorbell_chime_seq: four parameter variants
// share one stimulus bus; each scenario checks one variant cycle by cycle.
module tb_doorbell_chime_seq;

    typedef struct {
        logic [7:0] o;
        logic       b;
        logic       d;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] snd;
    logic [1:0]  sel;
    logic        press;

    logic [7:0] out0, out1, out2, out3;
    logic       busy0, busy1, busy2, busy3;
    logic       done0, done1, done2, done3;

    int checks;
    int errors;

    logic       pv [0:63];
    logic [1:0] sv [0:63];
    logic [7:0] eo [0:63];
    logic       eb [0:63];
    logic       ed [0:63];
    exp_t       q [$];

    doorbell_chime_seq #(.RETRIG(0)) u_def (
        .clk(clk), .rst_n(rst_n), .snd(snd), .sel(sel), .press(press),
        .out(out0), .busy(busy0), .done(done0)
    );

    doorbell_chime_seq #(.RETRIG(1)) u_rtg (
        .clk(clk), .rst_n(rst_n), .snd(snd), .sel(sel), .press(press),
        .out(out1), .busy(busy1), .done(done1)
    );

    doorbell_chime_seq #(.NCH(3)) u_n3 (
        .clk(clk), .rst_n(rst_n), .snd(snd[23:0]), .sel(sel),
        .press(press), .out(out2), .busy(busy2), .done(done2)
    );

    doorbell_chime_seq #(.DELAY(1), .HOLD(1)) u_min (
        .clk(clk), .rst_n(rst_n), .snd(snd), .sel(sel), .press(press),
        .out(out3), .busy(busy3), .done(done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s got %0h want %0h", tag, obs, want);
        end
    endtask

    task automatic prep();
        for (int i = 0; i < 64; i++) begin
            pv[i] = 1'b0;
            sv[i] = 2'd0;
            eo[i] = 8'h00;
            eb[i] = 1'b0;
            ed[i] = 1'b0;
        end
        q.delete();
    endtask

    task automatic set_press(input int a, input int b, input logic [1:0] s);
        for (int i = a; i <= b; i++) begin
            pv[i] = 1'b1;
            sv[i] = s;
        end
    endtask

    task automatic set_busy(input int a, input int b);
        for (int i = a; i <= b; i++) eb[i] = 1'b1;
    endtask

    task automatic set_out(input int a, input int b, input logic [7:0] v);
        for (int i = a; i <= b; i++) eo[i] = v;
    endtask

    task automatic push_exp(input int n);
        for (int c = 1; c <= n; c++) begin
            exp_t e;
            e.o = eo[c];
            e.b = eb[c];
            e.d = ed[c];
            q.push_back(e);
        end
    endtask

    task automatic do_reset(input logic hold);
        rst_n = 1'b0;
        press = hold;
        sel   = 2'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.out", out0, 8'h00);
        chk("rst.busy", {7'd0, busy0}, 8'h00);
        chk("rst.done", {7'd0, done0}, 8'h00);
        rst_n = 1'b1;
    endtask

    task automatic run(input int n, input int which, input string tag);
        logic [7:0] o;
        logic       b;
        logic       d;
        exp_t       e;
        for (int c = 1; c <= n; c++) begin
            press = pv[c];
            sel   = sv[c];
            @(posedge clk);
            @(negedge clk);
            case (which)
                0: begin o = out0; b = busy0; d = done0; end
                1: begin o = out1; b = busy1; d = done1; end
                2: begin o = out2; b = busy2; d = done2; end
                default: begin o = out3; b = busy3; d = done3; end
            endcase
            if (q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL %s.queue empty at cycle %0d", tag, c);
            end else begin
                e = q.pop_front();
                chk($sformatf("%s.out@%0d", tag, c), o, e.o);
                chk($sformatf("%s.busy@%0d", tag, c), {7'd0, b}, {7'd0, e.b});
                chk($sformatf("%s.done@%0d", tag, c), {7'd0, d}, {7'd0, e.d});
            end
        end
    endtask

    task automatic exp_basic(input logic [7:0] v);
        set_busy(10, 22);
        set_out(15, 22, v);
        ed[23] = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        snd    = 32'h0;
        sel    = 2'd0;
        press  = 1'b0;

        // basic play
        do_reset(1'b0);
        prep();
        snd = 32'h00A5_0000;
        set_press(10, 12, 2'd2);
        exp_basic(8'hA5);
        push_exp(30);
        run(30, 0, "basic");

        // press held for 30 cycles
        do_reset(1'b0);
        prep();
        snd = 32'h00A5_1100;
        set_press(10, 39, 2'd2);
        set_press(11, 39, 2'd1);
        exp_basic(8'hA5);
        push_exp(45);
        run(45, 0, "held");

        // second rise in PLAY cycle 3 ignored without retrigger
        do_reset(1'b0);
        prep();
        set_press(10, 11, 2'd2);
        set_press(13, 20, 2'd1);
        exp_basic(8'hA5);
        push_exp(30);
        run(30, 0, "ignore");

        // retrigger
        do_reset(1'b0);
        prep();
        snd = 32'h3CA5_1100;
        set_press(10, 11, 2'd2);
        set_press(14, 15, 2'd3);
        set_busy(10, 26);
        set_out(15, 18, 8'hA5);
        set_out(19, 26, 8'h3C);
        ed[27] = 1'b1;
        push_exp(32);
        run(32, 1, "retrig");

        // out-of-range select on a 3-channel variant
        do_reset(1'b0);
        prep();
        snd = 32'h0033_2211;
        set_press(10, 12, 2'd3);
        exp_basic(8'h00);
        push_exp(30);
        run(30, 2, "oor");

        // async reset in PLAY cycle 4
        do_reset(1'b0);
        prep();
        snd = 32'h00A5_0000;
        set_press(10, 12, 2'd2);
        exp_basic(8'hA5);
        push_exp(30);
        run(14, 0, "rplay");
        rst_n = 1'b0;
        #1;
        chk("rplay.out", out0, 8'h00);
        chk("rplay.busy", {7'd0, busy0}, 8'h00);
        chk("rplay.done", {7'd0, done0}, 8'h00);

        // async reset while data is on the output
        do_reset(1'b0);
        prep();
        set_press(10, 12, 2'd2);
        exp_basic(8'hA5);
        push_exp(30);
        run(17, 0, "rdrain");
        rst_n = 1'b0;
        #1;
        chk("rdrain.out", out0, 8'h00);
        chk("rdrain.busy", {7'd0, busy0}, 8'h00);
        chk("rdrain.done", {7'd0, done0}, 8'h00);

        // fresh chime after reset: delay line must be clean
        do_reset(1'b0);
        prep();
        snd = 32'h0000_5A00;
        set_press(3, 5, 2'd1);
        set_busy(3, 15);
        set_out(8, 15, 8'h5A);
        ed[16] = 1'b1;
        push_exp(20);
        run(20, 0, "clean");

        // minimum parameters, press held through reset release,
        // earliest re-acceptance and a rise on the return edge
        do_reset(1'b1);
        prep();
        snd = 32'h3CA5_0000;
        set_press(1, 2, 2'd2);
        set_press(4, 4, 2'd3);
        set_press(6, 8, 2'd2);
        set_press(10, 10, 2'd2);
        set_busy(1, 2);
        eo[2] = 8'hA5;
        ed[3] = 1'b1;
        set_busy(4, 5);
        eo[5] = 8'h3C;
        ed[6] = 1'b1;
        set_busy(10, 11);
        eo[11] = 8'hA5;
        ed[12] = 1'b1;
        push_exp(15);
        run(15, 3, "min");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/doorbell_chime_seq.md
# doorbell_chime_seq

Parametrised, clocked successor to the two-input doorbell chime multiplexer. Selects one of NCH sound-sample channels on a button press, plays it for HOLD cycles, and presents the result after a fixed DELAY-cycle pipeline latency (clock cycles, not simulation ticks). Sits between the sound-source generators and the speaker driver. Reports `busy` and `done` to the doorbell controller.

## Interface
- `NCH`, 4: number of sound channels (≥2); `SW = $clog2(NCH)`
- `W`, 8: sample width in bits (≥1)
- `DELAY`, 5: output latency in clock cycles (≥1)
- `HOLD`, 8: play duration in cycles per press (≥1)
- `RETRIG`, 0: 1 means a press during PLAY restarts the play window
- `clk` in 1: single clock; all state changes on its rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `snd` in NCH*W: channel c occupies bits `[c*W +: W]`
- `sel` in SW: channel select, sampled only on an accepted press
- `press` in 1: doorbell button level; only its rising edge triggers
- `out` out W: delayed, gated sample
- `busy` out 1: high in PLAY and DRAIN
- `done` out 1: one-cycle pulse when a chime fully completes

## Operation
- **Edge detect:** `press_q` registers `press` every cycle. `rise = press & ~press_q`. A level held high produces one trigger only.
- **States:** IDLE, PLAY, DRAIN.
- **IDLE:**
  - If `rise`: latch `sel_q <= sel`, load `cnt <= HOLD-1`, go to PLAY.
  - Otherwise stay in IDLE.
- **PLAY:**
  - Gated sample `g = snd[sel_q]`.
  - If `sel_q >= NCH`, `g = 0`; the chime still plays silently for the full timing.
  - If `cnt == 0`: load `cnt <= DELAY-1`, go to DRAIN. Otherwise `cnt--`.
  - If `RETRIG=1` and `rise`: re-latch `sel_q`, reload `cnt <= HOLD-1`, stay in PLAY. Retrigger has priority over the `cnt == 0` exit.
  - If `RETRIG=0`: presses are ignored.
- **DRAIN:**
  - `g = 0`. Presses are ignored.
  - If `cnt == 0`: go to IDLE and assert `done` for one cycle. Otherwise `cnt--`.
- **Gating:** `g = 0` in IDLE and DRAIN.
- **Delay line:** DELAY W-bit registers. Stage 0 loads `g` every cycle; `out` is the last stage. The line shifts in all states.
- **Counter:** `cnt` width `$clog2(max(HOLD, DELAY)+1)`; it never wraps.
- **Reset:** asserting `rst_n=0` at any time, including mid-PLAY or mid-DRAIN, immediately clears everything:
  - `out=0`, `busy=0`, `done=0`
  - state IDLE; `cnt`, `sel_q`, `press_q` and all delay stages cleared
  - A press held high through reset release is seen as a rising edge on the first clock after release.

## Timing
Cycle n is the interval after rising edge n.
- If `rise` is true at edge k (in IDLE):
  - PLAY occupies cycles k … k+HOLD-1.
  - DRAIN occupies cycles k+HOLD … k+HOLD+DELAY-1.
  - IDLE resumes at k+HOLD+DELAY.
- `out` in cycle n+DELAY equals `g` in cycle n. So `out` carries channel data in cycles k+DELAY … k+DELAY+HOLD-1.
- `busy` is high in cycles k … k+HOLD+DELAY-1. The last non-zero `out` cycle is the final DRAIN cycle.
- `done` is registered: high in cycle k+HOLD+DELAY only, concurrent with `busy=0`.
- **Back-to-back presses:** a rise at the same edge that returns to IDLE is not accepted. The earliest new acceptance is edge k+HOLD+DELAY+1.
- **`snd` changes during PLAY:** they are passed through cycle by cycle; channel data is not latched, only `sel` is.
- **Retrigger (`RETRIG=1`):** a rise at edge r during PLAY extends PLAY to cycle r+HOLD-1.

## Test plan
All scenarios use NCH=4, W=8, DELAY=5, HOLD=8 unless noted.
- **Basic play:** ch2=8'hA5, others 0, `sel=2`, press rises with accept edge k=10.
  - `out=8'hA5` in cycles 15–22, else 0.
  - `busy` high in cycles 10–22.
  - `done` high in cycle 23 only.
- **Held press and ignored press (RETRIG=0):** `press` held high for 30 cycles; separately, a second rise at PLAY cycle 3 with `sel=1`.
  - Exactly one chime.
  - `out` stays ch2 data.
  - Window length unchanged (8 cycles).
- **Retrigger (RETRIG=1):** rise at k=10 (`sel=2`), then rise at edge 14 (`sel=3`, ch3=8'h3C).
  - `out` is ch2 in cycles 15–18, then 8'h3C in cycles 19–26.
  - `done` in cycle 27.
- **Out-of-range select:** NCH=3, SW=2, `sel=3`.
  - `out` stays 0 throughout.
  - `busy`/`done` timing identical to the basic-play scenario.
- **Async reset mid-chime:** drop `rst_n` in PLAY cycle 4.
  - `out`, `busy`, `done` go to 0 immediately, with no `done` pulse.
  - After release, a new press plays normally from a clean delay line.
- **Minimum parameters:** DELAY=1, HOLD=1.
  - Rise at k gives `out` = channel data in cycle k+1 only.
  - `busy` in cycles k … k+1.
  - `done` in cycle k+2.
